adc_unpack: RTL and testbench
=============================

// Module: adc_unpack
// PURPOSE
//  Inverse of the ADC packer: takes 64-bit packed words (four 14-bit samples, one per 16-bit
//  lane, lane 0 = oldest) and re-serialises them into one 14-bit sample per accepted cycle.
//  Sits on the consumer side of the packed-word path and feeds per-sample processing at i_125clk.
//  Provides word-in / sample-out valid-ready handshakes, a two-word buffer and pad-bit checking.
// PARAMETERS
//  SAMPLE_W  14  sample width; sample n occupies word[n*LANE_W +: SAMPLE_W]
//  LANE_W    16  lane pitch in bits; bits [n*16+15:n*16+14] are pad and must be 0
//  LANES     4   samples per word; WORD_W = LANES*LANE_W = 64
//  CNT_W     16  width of o_word_count
// PORTS
//  i_125clk        in   1   sole clock, rising edge
//  i_nreset        in   1   asynchronous, active-low reset
//  i_word          in   64  packed input word
//  i_word_valid    in   1   i_word valid this cycle
//  o_word_ready    out  1   block can accept a word this cycle
//  o_sample        out  14  current output sample
//  o_lane          out  2   lane index of o_sample (0..3)
//  o_sample_valid  out  1   o_sample/o_lane valid
//  i_sample_ready  in   1   downstream accepts sample this cycle
//  o_pad_err       out  1   sticky: an accepted word had a nonzero pad bit
//  o_word_count    out  16  count of accepted words, wraps
// BEHAVIOUR
//  - Reset (async assert, any cycle): cur/next buffers empty, lane=0, o_sample=0, o_lane=0,
//    o_sample_valid=0, o_pad_err=0, o_word_count=0, o_word_ready=1. Mid-word data is discarded.
//  - Word accept: i_word_valid & o_word_ready at rising edge. o_word_ready = !next_valid (registered
//    state only; no combinational path from i_sample_ready or i_word_valid).
//  - Storage: CUR (word being emitted) + NEXT (one waiting word). Accepted word goes to CUR if CUR
//    empty or CUR is finishing this cycle (lane 3 accepted) and NEXT empty; otherwise to NEXT.
//    When CUR finishes and NEXT is full, NEXT moves to CUR, NEXT empties, same edge.
//  - States: EMPTY (no CUR) -> EMIT on accept; EMIT advances lane on each sample handshake
//    (o_sample_valid & i_sample_ready); at lane 3 handshake -> EMIT lane 0 if a word is
//    available (NEXT or same-cycle accept), else EMPTY.
//  - Output: o_sample = CUR[lane*16 +: 14], o_lane = lane, o_sample_valid = CUR valid; all driven
//    from registers. Latency: word accepted at edge N -> lane 0 valid in cycle after edge N.
//  - Throughput: with i_sample_ready=1 and a word every 4 cycles, o_sample_valid stays high
//    continuously (no bubble between lane 3 and next lane 0).
//  - Backpressure: while o_sample_valid & !i_sample_ready, o_sample/o_lane held stable; no loss.
//  - Pad check: on accept, if any of bits 15:14, 31:30, 47:46, 63:62 of i_word set, o_pad_err
//    goes 1 next cycle and stays 1 until reset; samples still emitted from data bits only.
//  - o_word_count increments by 1 per accepted word, 0xFFFF -> 0x0000 wrap.
//  - Simultaneous accept + CUR finish + NEXT empty: new word loads straight into CUR, lane 0.
// TESTING
//  1 Reset: hold i_nreset=0 -> all outputs 0, o_word_ready=1; release mid-stream -> restarts clean.
//  2 Single word 0x0003_0002_0001_0000, ready=1 -> samples 0,1,2,3 lanes 0..3 on 4 consecutive
//    cycles starting 1 cycle after accept; o_word_count=1; o_pad_err=0.
//  3 Ramp words k*0x0001_0001_0001_0001 (k=0..99) every 4 cycles, ready=1 -> o_sample_valid
//    never drops after first sample; each k appears 4 times, lanes 0..3 in order; count=100.
//  4 i_sample_ready=0 for 20 cycles with words offered -> 2 words accepted then o_word_ready=0;
//    o_sample held at first value; on release all 8 samples delivered in order, none lost.
//  5 Word 0x4000_0000_0000_0005 -> o_pad_err=1 next cycle, lane3 sample=0x0000, lane0=5; stays 1.
//  6 Assert i_nreset at lane 2 -> outputs zero immediately; next word emits from lane 0;
//    65536 accepted words from reset -> o_word_count=0x0000.

Source files
------------

// File: rtl/adc_unpack_if.sv
// Purpose: bundles the packed-word input handshake and sample output handshake of adc_unpack.
// Latency: none (wires only).
// Backpressure: carries o_word_ready upstream and i_sample_ready from downstream.
// Signals: i_word/i_word_valid/o_word_ready (word side), o_sample/o_lane/o_sample_valid/
//          i_sample_ready (sample side), o_pad_err, o_word_count (status).
interface adc_unpack_if #(
  parameter int SAMPLE_W = 14,
  parameter int LANE_W   = 16,
  parameter int LANES    = 4,
  parameter int CNT_W    = 16
);
  localparam int WORD_W  = LANES * LANE_W;
  localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [WORD_W-1:0]   i_word;
  logic                i_word_valid;
  logic                o_word_ready;
  logic [SAMPLE_W-1:0] o_sample;
  logic [LANE_IW-1:0]  o_lane;
  logic                o_sample_valid;
  logic                i_sample_ready;
  logic                o_pad_err;
  logic [CNT_W-1:0]    o_word_count;

  // Block side.
  modport slave (
    input  i_word, i_word_valid, i_sample_ready,
    output o_word_ready, o_sample, o_lane, o_sample_valid, o_pad_err, o_word_count
  );

  // Producer/consumer side.
  modport master (
    output i_word, i_word_valid, i_sample_ready,
    input  o_word_ready, o_sample, o_lane, o_sample_valid, o_pad_err, o_word_count
  );
endinterface

// File: rtl/adc_unpack.sv
// Purpose: re-serialises 64-bit packed words (4 x 14-bit samples, lane 0 oldest) into one sample per handshake.
// Latency: word accepted at edge N -> lane 0 valid in the cycle after edge N; no bubble between words.
// Backpressure: sample held stable while !i_sample_ready; two-word buffer, o_word_ready = !next-buffer-full.
// Ports: i_125clk, i_nreset (async active-low), bus (adc_unpack_if.slave: word in, sample out, pad_err, word_count).
module adc_unpack #(
  parameter int SAMPLE_W = 14,
  parameter int LANE_W   = 16,
  parameter int LANES    = 4,
  parameter int CNT_W    = 16
) (
  input  logic       i_125clk,
  input  logic       i_nreset,
  adc_unpack_if.slave bus
);
  localparam int WORD_W  = LANES * LANE_W;
  localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PAD_W   = LANE_W - SAMPLE_W;

  typedef enum logic {ST_EMPTY, ST_EMIT} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   cur_q, cur_d;
  logic [WORD_W-1:0]   nxt_q, nxt_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic [LANE_IW-1:0]  lane_q, lane_d;
  logic                pad_err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic word_acc;
  logic smp_hs;
  logic last_lane;
  logic pad_hit;

  // Ready depends only on the registered next-buffer state, so there is no
  // combinational path from either valid or the downstream ready.
  assign bus.o_word_ready = !nxt_vld_q;
  assign word_acc         = bus.i_word_valid && !nxt_vld_q;
  assign smp_hs           = (state_q == ST_EMIT) && bus.i_sample_ready;
  assign last_lane        = (lane_q == LANE_IW'(LANES - 1));

  always_comb begin
    pad_hit = 1'b0;
    for (int n = 0; n < LANES; n++) begin
      pad_hit = pad_hit | (|bus.i_word[n*LANE_W+SAMPLE_W +: PAD_W]);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    nxt_vld_d = nxt_vld_q;
    lane_d    = lane_q;
    case (state_q)
      ST_EMPTY: begin
        // NEXT is always empty here, so an arriving word goes straight to CUR.
        if (word_acc) begin
          cur_d   = bus.i_word;
          lane_d  = '0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (smp_hs && last_lane) begin
          lane_d = '0;
          if (nxt_vld_q) begin
            // word_acc is impossible here because ready is low while NEXT is full.
            cur_d     = nxt_q;
            nxt_vld_d = 1'b0;
          end else if (word_acc) begin
            cur_d = bus.i_word;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          if (smp_hs) begin
            lane_d = lane_q + 1'b1;
          end
          if (word_acc) begin
            nxt_d     = bus.i_word;
            nxt_vld_d = 1'b1;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_125clk or negedge i_nreset) begin
    if (!i_nreset) begin
      state_q   <= ST_EMPTY;
      cur_q     <= '0;
      nxt_q     <= '0;
      nxt_vld_q <= 1'b0;
      lane_q    <= '0;
      pad_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      nxt_vld_q <= nxt_vld_d;
      lane_q    <= lane_d;
      if (word_acc) begin
        cnt_q <= cnt_q + 1'b1;
        if (pad_hit) begin
          pad_err_q <= 1'b1;
        end
      end
    end
  end

  // Cleared CUR on reset makes o_sample read zero until the first word lands.
  assign bus.o_sample       = cur_q[lane_q*LANE_W +: SAMPLE_W];
  assign bus.o_lane         = lane_q;
  assign bus.o_sample_valid = (state_q == ST_EMIT);
  assign bus.o_pad_err      = pad_err_q;
  assign bus.o_word_count   = cnt_q;
endmodule

// File: tb/tb_adc_unpack.sv
module tb_adc_unpack;
  localparam logic [63:0] PAD_MASK = 64'hC000_C000_C000_C000;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  adc_unpack_if b ();
  adc_unpack_if #(.CNT_W(4)) bs ();

  // Narrow-counter copy sees identical traffic so counter wrap is reachable quickly.
  assign bs.i_word         = b.i_word;
  assign bs.i_word_valid   = b.i_word_valid;
  assign bs.i_sample_ready = b.i_sample_ready;

  adc_unpack u_dut (.i_125clk(clk), .i_nreset(nrst), .bus(b));
  adc_unpack #(.CNT_W(4)) u_small (.i_125clk(clk), .i_nreset(nrst), .bus(bs));

  typedef struct packed {
    logic [1:0]  lane;
    logic [13:0] smp;
  } exp_t;

  exp_t exp_q[$];
  logic model_pad;
  int   model_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_pad = 1'b0;
    model_cnt = 0;
  endtask

  task automatic push_word(input logic [63:0] w);
    exp_t e;
    for (int n = 0; n < 4; n++) begin
      e.lane = 2'(n);
      e.smp  = 14'((w >> (16 * n)) & 64'h3FFF);
      exp_q.push_back(e);
    end
    model_cnt = (model_cnt + 1) % 65536;
    if ((w & PAD_MASK) != 64'd0) model_pad = 1'b1;
  endtask

  task automatic check_outputs();
    chk("valid", b.o_sample_valid, exp_q.size() != 0);
    chk("ready", b.o_word_ready, exp_q.size() <= 4);
    if (exp_q.size() != 0) begin
      chk("sample", b.o_sample, exp_q[0].smp);
      chk("lane", b.o_lane, exp_q[0].lane);
    end
    chk("pad_err", b.o_pad_err, model_pad);
    chk("count", b.o_word_count, model_cnt[15:0]);
    chk("count_small", bs.o_word_count, model_cnt[3:0]);
  endtask

  task automatic cyc(input logic wv, input logic [63:0] w, input logic sr);
    logic acc, hs;
    @(negedge clk);
    b.i_word_valid   = wv;
    b.i_word         = w;
    b.i_sample_ready = sr;
    #1;
    check_outputs();
    acc = wv && b.o_word_ready;
    hs  = b.o_sample_valid && sr;
    last_acc = acc;
    @(posedge clk);
    if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) push_word(w);
  endtask

  // Asynchronous assert a little after a rising edge; outputs must clear at once.
  task automatic apply_reset();
    #2;
    nrst = 1'b0;
    b.i_word_valid   = 1'b0;
    b.i_word         = '0;
    b.i_sample_ready = 1'b0;
    #1;
    model_clear();
    chk("rst_sample", b.o_sample, 0);
    chk("rst_lane", b.o_lane, 0);
    chk("rst_valid", b.o_sample_valid, 0);
    chk("rst_pad", b.o_pad_err, 0);
    chk("rst_count", b.o_word_count, 0);
    chk("rst_ready", b.o_word_ready, 1);
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && exp_q.size() > 0; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] w;
    logic        have;
    int          nacc;

    b.i_word_valid   = 1'b0;
    b.i_word         = '0;
    b.i_sample_ready = 1'b0;
    model_clear();

    // Reset from time zero.
    @(posedge clk);
    apply_reset();

    // Single word: samples 0..3 on consecutive cycles.
    cyc(1'b1, 64'h0003_0002_0001_0000, 1'b1);
    chk("single_acc", last_acc, 1);
    drain();
    chk("single_count", b.o_word_count, 1);

    // Ramp words every 4 cycles, continuous output.
    for (int k = 0; k < 100; k++) begin
      w = 64'(k) * 64'h0001_0001_0001_0001;
      cyc(1'b1, w, 1'b1);
      chk("ramp_acc", last_acc, 1);
      for (int j = 0; j < 3; j++) cyc(1'b0, 64'd0, 1'b1);
    end
    drain();
    chk("ramp_count", b.o_word_count, 101);

    // Backpressure: only two words fit while the sink stalls.
    nacc = 0;
    have = 1'b0;
    w = '0;
    for (int i = 0; i < 20; i++) begin
      if (!have) begin
        w = {$urandom, $urandom} & ~PAD_MASK;
        have = 1'b1;
      end
      cyc(1'b1, w, 1'b0);
      if (last_acc) begin
        nacc++;
        have = 1'b0;
      end
    end
    chk("bp_accepts", nacc, 2);
    drain();

    // Random traffic and random sink stalls.
    have = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!have) begin
        w = {$urandom, $urandom} & ~PAD_MASK;
        have = 1'b1;
      end
      cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0);
      if (last_acc) have = 1'b0;
    end
    drain();

    // Pad bit set in lane 3.
    cyc(1'b1, 64'h4000_0000_0000_0005, 1'b1);
    chk("pad_acc", last_acc, 1);
    #1;
    chk("pad_next_cycle", b.o_pad_err, 1);
    drain();
    for (int i = 0; i < 5; i++) cyc(1'b0, 64'd0, 1'b1);
    chk("pad_sticky", b.o_pad_err, 1);

    // Reset at lane 2 mid-word, then restart from lane 0.
    cyc(1'b1, 64'h0123_0456_0789_0ABC, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    cyc(1'b0, 64'd0, 1'b1);
    #1;
    chk("pre_reset_lane", b.o_lane, 2);
    apply_reset();
    cyc(1'b1, 64'h1111_2222_3333_0ACE, 1'b1);
    drain();
    chk("post_reset_count", b.o_word_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
